// File: rtl/box_pkg.sv
// Shared definitions for the box drawer: FSM states, screen defaults and field widths.
package box_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAW  = 2'd1,
    CLEAR = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int SCR_W_DFLT = 160;
  localparam int SCR_H_DFLT = 120;
  localparam int X_W        = 8;
  localparam int Y_W        = 7;

  localparam logic [2:0] BLACK = 3'b000;

endpackage

// File: rtl/box_drawer_if.sv
// Switch/key control inputs and VGA adapter write port of the box drawer.
interface box_drawer_if;
  import box_pkg::*;

  logic [7:0]     data_in;
  logic [2:0]     colour_in;
  logic           ld_x;
  logic           ld_y;
  logic           go;
  logic           clear;
  logic [X_W-1:0] vga_x;
  logic [Y_W-1:0] vga_y;
  logic [2:0]     vga_colour;
  logic           vga_plot;
  logic           busy;
  logic           done;

  modport master (
    output data_in, colour_in, ld_x, ld_y, go, clear,
    input  vga_x, vga_y, vga_colour, vga_plot, busy, done
  );

  modport slave (
    input  data_in, colour_in, ld_x, ld_y, go, clear,
    output vga_x, vga_y, vga_colour, vga_plot, busy, done
  );

endinterface

// File: rtl/pixel_scan_counter.sv
// Row-major 2-D scan counter: cx runs 0..width-1 inside cy 0..height-1, then wraps.
module pixel_scan_counter
  import box_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic [X_W-1:0] width,
  input  logic [Y_W-1:0] height,
  input  logic           en,
  input  logic           load_zero,
  output logic [X_W-1:0] cx,
  output logic [Y_W-1:0] cy,
  output logic           last
);

  logic row_end;
  logic col_end;

  assign row_end = (cx == width - 1'b1);
  assign col_end = (cy == height - 1'b1);
  assign last    = row_end && col_end;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cx <= '0;
      cy <= '0;
    end else if (load_zero) begin
      cx <= '0;
      cy <= '0;
    end else if (en) begin
      if (row_end) begin
        cx <= '0;
        cy <= col_end ? '0 : cy + 1'b1;
      end else begin
        cx <= cx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/box_drawer.sv
// Draws a clipped BOX_W x BOX_H filled box, one pixel per clock, into the VGA adapter.
// Define CLEAR_SCREEN_EN to add a full-screen black sweep on the clear request.
module box_drawer
  import box_pkg::*;
#(
  parameter int BOX_W = 4,
  parameter int BOX_H = 4,
  parameter int SCR_W = SCR_W_DFLT,
  parameter int SCR_H = SCR_H_DFLT
) (
  input  logic  CLOCK_50,
  input  logic  resetn,
  box_drawer_if.slave bus
);

  state_t         state;
  logic [X_W-1:0] x_reg;
  logic [Y_W-1:0] y_reg;
  logic [2:0]     col_reg;
  logic           final_px;

  logic           start_draw, start_clear, clear_sel, clear_lvl;
  logic           emit, cnt_zero, cnt_last, in_scr;
  logic [X_W-1:0] cnt_w, cx, x_nxt, x_base;
  logic [Y_W-1:0] cnt_h, cy, y_nxt, y_base;
  logic [X_W:0]   sx;
  logic [Y_W:0]   sy;
  logic [2:0]     px_col;

`ifndef CLEAR_SCREEN_EN
  logic unused_clear;
  assign unused_clear = bus.clear;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    start_clear = 1'b0;
    clear_lvl   = 1'b0;
`ifdef CLEAR_SCREEN_EN
    start_clear = (state == IDLE) && bus.clear;
    clear_lvl   = bus.clear;
`endif
    start_draw = (state == IDLE) && bus.go && !start_clear;
    clear_sel  = start_clear || (state == CLEAR);

    // The pixel emitted on the go edge already uses origin values loaded on that same edge.
    x_nxt = bus.ld_x ? bus.data_in      : x_reg;
    y_nxt = bus.ld_y ? bus.data_in[6:0] : y_reg;

    cnt_w  = clear_sel ? X_W'(SCR_W) : X_W'(BOX_W);
    cnt_h  = clear_sel ? Y_W'(SCR_H) : Y_W'(BOX_H);
    x_base = clear_sel ? '0 : ((state == IDLE) ? x_nxt : x_reg);
    y_base = clear_sel ? '0 : ((state == IDLE) ? y_nxt : y_reg);
    px_col = clear_sel ? BLACK : ((state == IDLE) ? bus.colour_in : col_reg);

    sx     = {1'b0, x_base} + {1'b0, cx};
    sy     = {1'b0, y_base} + {1'b0, cy};
    in_scr = (sx < (X_W+1)'(SCR_W)) && (sy < (Y_W+1)'(SCR_H));

    emit     = start_draw || start_clear ||
               (((state == DRAW) || (state == CLEAR)) && !final_px);
    cnt_zero = ((state == IDLE) && !emit) || (state == DONE);
  end

  pixel_scan_counter u_scan (
    .clk       (CLOCK_50),
    .rst_n     (resetn),
    .width     (cnt_w),
    .height    (cnt_h),
    .en        (emit),
    .load_zero (cnt_zero),
    .cx        (cx),
    .cy        (cy),
    .last      (cnt_last)
  );

  // The counter runs one pixel ahead of the output registers; final_px marks that
  // the pixel now on the outputs was the last one of the sweep.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      x_reg          <= '0;
      y_reg          <= '0;
      col_reg        <= '0;
      final_px       <= 1'b0;
      bus.vga_x      <= '0;
      bus.vga_y      <= '0;
      bus.vga_colour <= '0;
      bus.vga_plot   <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
    end else begin
      bus.vga_plot <= emit && in_scr;
      if (emit) begin
        bus.vga_x      <= sx[X_W-1:0];
        bus.vga_y      <= sy[Y_W-1:0];
        bus.vga_colour <= px_col;
        final_px       <= cnt_last;
      end

      case (state)
        IDLE: begin
          x_reg <= x_nxt;
          y_reg <= y_nxt;
          if (start_clear) begin
            state    <= CLEAR;
            bus.busy <= 1'b1;
          end else if (start_draw) begin
            state    <= DRAW;
            col_reg  <= bus.colour_in;
            bus.busy <= 1'b1;
          end
        end
        DRAW, CLEAR: begin
          if (final_px) begin
            state    <= DONE;
            final_px <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end
        end
        DONE: begin
          if (!bus.go && !clear_lvl) begin
            state    <= IDLE;
            bus.done <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_box_drawer.sv
// Self-checking bench for box_drawer: directed table, corner-case sequences and random draws.
module tb_box_drawer;
  import box_pkg::*;

  localparam int BW = 4;
  localparam int BH = 4;

  logic clk;
  logic resetn;
  int   n_checks = 0;
  int   n_pass   = 0;

  box_drawer_if bus ();

  box_drawer #(.BOX_W(BW), .BOX_H(BH), .SCR_W(160), .SCR_H(120)) dut (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         x;
    int         y;
    logic [2:0] col;
    int         exp_plots;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic sample();
    @(posedge clk);
    #1;
  endtask

  // Reference pixel k of a box at (x,y): row-major position, clipped against the screen.
  function automatic logic [18:0] model_px(input int x, input int y, input logic [2:0] col,
                                           input int k);
    int  ex, ey;
    logic plot;
    ex   = x + (k % BW);
    ey   = y + (k / BW);
    plot = (ex < 160) && (ey < 120);
    return {plot, 8'(ex), 7'(ey), col};
  endfunction

  task automatic run_draw(input bit load, input int x, input int y, input logic [2:0] col,
                          input bit noise, input int lockout_at, output int plots);
    logic [18:0] act;
    @(negedge clk);
    if (load) begin
      bus.data_in = 8'(y);
      bus.ld_y    = 1'b1;
      @(negedge clk);
      bus.ld_y    = 1'b0;
      bus.data_in = 8'(x);
      bus.ld_x    = 1'b1;
      @(negedge clk);
      bus.ld_x    = 1'b0;
    end
    bus.colour_in = col;
    bus.go        = 1'b1;
    plots = 0;
    for (int k = 0; k < BW*BH; k++) begin
      sample();
      act = {bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour};
      check($sformatf("pixel%0d", k), 32'(act), 32'(model_px(x, y, col, k)));
      check("busy_in_draw", 32'(bus.busy), 32'd1);
      if (bus.vga_plot) plots++;
      bus.ld_x = (k == lockout_at);
      if (k == lockout_at) bus.data_in = 8'h10;
      if (noise) begin
        bus.go        = 1'($urandom);
        bus.colour_in = 3'($urandom);
      end
    end
    sample();
    check("done_after_draw", 32'({bus.done, bus.busy, bus.vga_plot}), 32'b100);
  endtask

  task automatic finish_draw();
    @(negedge clk);
    bus.go = 1'b0;
    sample();
    check("idle_after_release", 32'({bus.done, bus.busy}), 32'b00);
  endtask

  initial begin
    vec_t tbl[7];
    int   plots;

    tbl[0] = '{158, 118, 3'b010, 4};
    tbl[1] = '{200,   0, 3'b111, 0};
    tbl[2] = '{  0, 125, 3'b001, 0};
    tbl[3] = '{157,   0, 3'b011, 12};
    tbl[4] = '{  0,   0, 3'b101, 16};
    tbl[5] = '{156, 116, 3'b110, 16};
    tbl[6] = '{159, 119, 3'b100, 1};

    resetn        = 1'b0;
    bus.data_in   = '0;
    bus.colour_in = '0;
    bus.ld_x      = 1'b0;
    bus.ld_y      = 1'b0;
    bus.go        = 1'b0;
    bus.clear     = 1'b0;
    repeat (3) sample();
    check("reset_outputs",
          32'({bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot, bus.busy, bus.done}), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    sample();
    check("idle_after_reset", 32'({bus.vga_plot, bus.busy, bus.done}), 32'd0);

    // Load + draw with go held: one draw, then done persists until go drops.
    run_draw(1'b1, 72, 72, 3'b100, 1'b0, -1, plots);
    check("basic_plot_count", 32'(plots), 32'd16);
    for (int i = 0; i < 5; i++) begin
      sample();
      check("held_go_single_draw", 32'({bus.done, bus.busy, bus.vga_plot}), 32'b100);
    end
    finish_draw();

    // Re-arm with the origin retained.
    run_draw(1'b0, 72, 72, 3'b011, 1'b0, -1, plots);
    check("rearm_plot_count", 32'(plots), 32'd16);
    finish_draw();

    for (int i = 0; i < 7; i++) begin
      run_draw(1'b1, tbl[i].x, tbl[i].y, tbl[i].col, 1'b0, -1, plots);
      check($sformatf("tbl%0d_plot_count", i), 32'(plots), 32'(tbl[i].exp_plots));
      finish_draw();
    end

    // ld_x during DRAW must not disturb this draw or the next one.
    run_draw(1'b1, 20, 30, 3'b110, 1'b0, 3, plots);
    finish_draw();
    run_draw(1'b0, 20, 30, 3'b001, 1'b0, -1, plots);
    check("lockout_next_count", 32'(plots), 32'd16);
    finish_draw();

    // Reset in the middle of a draw.
    @(negedge clk);
    bus.data_in = 8'd10;
    bus.ld_x    = 1'b1;
    bus.ld_y    = 1'b1;
    @(negedge clk);
    bus.ld_x      = 1'b0;
    bus.ld_y      = 1'b0;
    bus.colour_in = 3'b111;
    bus.go        = 1'b1;
    for (int k = 0; k < 5; k++) sample();
    check("fifth_pixel", 32'({bus.vga_plot, bus.vga_x, bus.vga_y}), 32'({1'b1, 8'd10, 7'd11}));
    resetn = 1'b0;
    #1;
    check("reset_abort",
          32'({bus.vga_plot, bus.busy, bus.vga_x, bus.vga_y}), 32'd0);
    bus.go = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    plots = 0;
    for (int i = 0; i < 20; i++) begin
      sample();
      if (bus.vga_plot || bus.busy || bus.done) plots++;
    end
    check("quiet_after_reset", 32'(plots), 32'd0);

    // Random origins/colours with go and colour_in toggling during DRAW.
    for (int i = 0; i < 20; i++) begin
      run_draw(1'b1, int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
               3'($urandom), 1'b1, -1, plots);
      finish_draw();
    end

`ifdef CLEAR_SCREEN_EN
    begin
      int bad = 0;
      @(negedge clk);
      bus.clear = 1'b1;
      bus.go    = 1'b1;
      plots = 0;
      for (int k = 0; k < 19200; k++) begin
        sample();
        if ({bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour} !==
            {1'b1, 8'(k % 160), 7'(k / 160), BLACK}) bad++;
        if (bus.vga_plot) plots++;
        if (k == 0)
          check("clear_first", 32'({bus.vga_x, bus.vga_y}), 32'({8'd0, 7'd0}));
        if (k == 19199)
          check("clear_last", 32'({bus.vga_x, bus.vga_y}), 32'({8'd159, 7'd119}));
      end
      check("clear_order", 32'(bad), 32'd0);
      check("clear_count", 32'(plots), 32'd19200);
      sample();
      check("clear_done", 32'({bus.done, bus.busy, bus.vga_plot}), 32'b100);
      @(negedge clk);
      bus.clear = 1'b0;
      bus.go    = 1'b0;
      sample();
      check("clear_exit", 32'(bus.done), 32'd0);
    end
`else
    @(negedge clk);
    bus.clear = 1'b1;
    plots = 0;
    for (int i = 0; i < 30; i++) begin
      sample();
      if (bus.vga_plot || bus.busy || bus.done) plots++;
    end
    check("clear_ignored", 32'(plots), 32'd0);
    @(negedge clk);
    bus.clear = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
